// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared FP32 constants and pooling FSM state type
package cnn_pkg;
  localparam int FP32_W    = 32;
  localparam int FP32_SIGN = 31;
  localparam logic [FP32_W-1:0] FP32_POS_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_WRITE,
    ST_FINISH
  } pool_state_t;
endpackage

// File: rtl/fp32_max.sv
// rtl/fp32_max.sv - combinational FP32 maximum on sign/magnitude ordering
module fp32_max
  import cnn_pkg::*;
(
  input  logic [FP32_W-1:0] a,
  input  logic [FP32_W-1:0] b,
  output logic [FP32_W-1:0] y
);
  always_comb begin
    y = a;
    if (a[FP32_SIGN] != b[FP32_SIGN]) begin
      y = a[FP32_SIGN] ? b : a;
    end else if (!a[FP32_SIGN]) begin
      y = (b[FP32_SIGN-1:0] > a[FP32_SIGN-1:0]) ? b : a;
    end else begin
      // both negative: the smaller magnitude is the larger value
      y = (b[FP32_SIGN-1:0] < a[FP32_SIGN-1:0]) ? b : a;
    end
  end
endmodule

// File: rtl/relu_maxpool_bram.sv
// rtl/relu_maxpool_bram.sv - optional ReLU + 2x2/2 max pool from C BRAM into P BRAM
module relu_maxpool_bram
  import cnn_pkg::*;
#(
  parameter int MAX_M       = 16,
  parameter int MAX_H       = 16,
  parameter int MAX_W       = 16,
  parameter int ADDR_M_BITS = $clog2(MAX_M),
  parameter int ADDR_H_BITS = $clog2(MAX_H),
  parameter int ADDR_W_BITS = $clog2(MAX_W),
  parameter int ADDR_C_BITS = $clog2(MAX_M*MAX_H*MAX_W),
  parameter int ADDR_P_BITS = $clog2(MAX_M*(MAX_H/2)*(MAX_W/2))
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   relu_en,
  input  logic [ADDR_M_BITS:0]   M_val,
  input  logic [ADDR_H_BITS:0]   H_val,
  input  logic [ADDR_W_BITS:0]   W_val,
  output logic                   done,
  output logic                   busy,
  output logic [ADDR_C_BITS-1:0] c_addr,
  input  logic [FP32_W-1:0]      c_rdata,
  output logic                   p_we,
  output logic [ADDR_P_BITS-1:0] p_addr,
  output logic [FP32_W-1:0]      p_wdata
);
  typedef logic [ADDR_M_BITS:0] m_t;
  typedef logic [ADDR_H_BITS:0] h_t;
  typedef logic [ADDR_W_BITS:0] w_t;

  pool_state_t      state;
  logic             relu_lat;
  m_t               m_lat, m_cnt, m_n;
  h_t               h_lat, ho_lat, ph, ph_n;
  w_t               w_lat, wo_lat, pw, pw_n;
  logic [1:0]       k;
  logic [FP32_W-1:0] acc, v, max_out;
  logic             last_out;

  function automatic logic [ADDR_C_BITS-1:0] c_index(input m_t mm, input h_t py, input w_t px,
                                                     input logic [1:0] kk, input h_t hh, input w_t ww);
    int row, col;
    row = 2*int'(py) + int'(kk[1]);
    col = 2*int'(px) + int'(kk[0]);
    return ADDR_C_BITS'(int'(mm)*int'(hh)*int'(ww) + row*int'(ww) + col);
  endfunction

  assign v = (relu_lat && c_rdata[FP32_SIGN]) ? FP32_POS_ZERO : c_rdata;

  fp32_max u_max (.a(acc), .b(v), .y(max_out));

  // window walk order: pw fastest, then ph, then channel
  always_comb begin
    pw_n     = pw + w_t'(1);
    ph_n     = ph;
    m_n      = m_cnt;
    last_out = 1'b0;
    if (pw == wo_lat - w_t'(1)) begin
      pw_n = '0;
      ph_n = ph + h_t'(1);
      if (ph == ho_lat - h_t'(1)) begin
        ph_n     = '0;
        m_n      = m_cnt + m_t'(1);
        last_out = (m_cnt == m_lat - m_t'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      done     <= 1'b0;
      busy     <= 1'b0;
      p_we     <= 1'b0;
      c_addr   <= '0;
      p_addr   <= '0;
      p_wdata  <= '0;
      relu_lat <= 1'b0;
      m_lat    <= '0;
      h_lat    <= '0;
      w_lat    <= '0;
      ho_lat   <= '0;
      wo_lat   <= '0;
      m_cnt    <= '0;
      ph       <= '0;
      pw       <= '0;
      k        <= '0;
      acc      <= '0;
    end else begin
      p_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            relu_lat <= relu_en;
            m_lat    <= M_val;
            h_lat    <= H_val;
            w_lat    <= W_val;
            ho_lat   <= H_val >> 1;
            wo_lat   <= W_val >> 1;
            m_cnt    <= '0;
            ph       <= '0;
            pw       <= '0;
            k        <= '0;
            acc      <= '0;
            done     <= 1'b0;
            busy     <= 1'b1;
            if (M_val == '0 || H_val[ADDR_H_BITS:1] == '0 || W_val[ADDR_W_BITS:1] == '0) begin
              state <= ST_FINISH;
            end else begin
              c_addr <= '0;
              state  <= ST_READ;
            end
          end
        end
        ST_READ: begin
          k      <= k + 2'd1;
          c_addr <= c_index(m_cnt, ph, pw, k + 2'd1, h_lat, w_lat);
          // data for sample k-1 is on c_rdata now
          if (k != 2'd0) acc <= (k == 2'd1) ? v : max_out;
          if (k == 2'd3) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          acc     <= max_out;
          p_we    <= 1'b1;
          p_addr  <= ADDR_P_BITS'(int'(m_cnt)*int'(ho_lat)*int'(wo_lat)
                                  + int'(ph)*int'(wo_lat) + int'(pw));
          p_wdata <= max_out;
          state   <= ST_WRITE;
        end
        ST_WRITE: begin
          m_cnt <= m_n;
          ph    <= ph_n;
          pw    <= pw_n;
          if (last_out) begin
            state <= ST_FINISH;
          end else begin
            c_addr <= c_index(m_n, ph_n, pw_n, 2'd0, h_lat, w_lat);
            state  <= ST_READ;
          end
        end
        ST_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_relu_maxpool_bram.sv
// tb/tb_relu_maxpool_bram.sv - table-driven and randomized bench for relu_maxpool_bram
module tb_relu_maxpool_bram;
  localparam int CB = 12;
  localparam int PB = 10;

  localparam int FILL_A   = 0;
  localparam int FILL_NEG = 1;
  localparam int FILL_IDX = 2;
  localparam int FILL_RND = 3;

  typedef struct {
    int m, h, w;
    bit relu;
    int fill;
    int glitch;
    int exp_n;
    int exp_cyc;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  typedef struct {
    int a;
    logic [31:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          relu_en = 1'b0;
  logic [4:0]    M_val = '0, H_val = '0, W_val = '0;
  logic          done, busy, p_we;
  logic [CB-1:0] c_addr;
  logic [31:0]   c_rdata = '0;
  logic [PB-1:0] p_addr;
  logic [31:0]   p_wdata;

  logic [31:0] cmem [0:4095];
  wr_t         wq[$];
  int          n_vec = 0, n_fail = 0;
  int          cur_m = 0, cur_h = 0, cur_w = 0;
  bit          job_empty = 1'b0;
  int          c_changes = 0, bad_addr = 0;
  logic [CB-1:0] last_c = '0;

  relu_maxpool_bram dut (
    .clk(clk), .rst_n(rst_n), .start(start), .relu_en(relu_en),
    .M_val(M_val), .H_val(H_val), .W_val(W_val),
    .done(done), .busy(busy), .c_addr(c_addr), .c_rdata(c_rdata),
    .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) c_rdata <= cmem[c_addr];

  function automatic bit addr_ok(int a);
    int plane, mm, r, c;
    plane = cur_h * cur_w;
    mm = a / plane;
    r  = (a % plane) / cur_w;
    c  = a % cur_w;
    return mm < cur_m && r < 2*(cur_h/2) && c < 2*(cur_w/2);
  endfunction

  always @(negedge clk) begin
    if (p_we) wq.push_back('{int'(p_addr), p_wdata});
    if (busy && c_addr !== last_c) c_changes++;
    last_c = c_addr;
    if (busy && !job_empty && !addr_ok(int'(c_addr))) bad_addr++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic longint fkey(logic [31:0] x);
    return x[31] ? -longint'(x[30:0]) : longint'(x[30:0]);
  endfunction

  function automatic logic [31:0] int_to_fp32(int i);
    int e;
    if (i == 0) return 32'h0;
    e = 0;
    while ((i >> (e + 1)) != 0) e++;
    return {1'b0, 8'(127 + e), 23'((i << (23 - e)) & 32'h7FFFFF)};
  endfunction

  task automatic fill_c(input int kind, input int n);
    logic [31:0] a_vals [4];
    logic [31:0] n_vals [4];
    logic [31:0] x;
    a_vals = '{32'h3F800000, 32'hC0000000, 32'h40600000, 32'h3F000000};
    n_vals = '{32'hBF800000, 32'hC0000000, 32'hBF000000, 32'hC0400000};
    for (int i = 0; i < n; i++) begin
      case (kind)
        FILL_A:   cmem[i] = a_vals[i % 4];
        FILL_NEG: cmem[i] = n_vals[i % 4];
        FILL_IDX: cmem[i] = int_to_fp32(i);
        default: begin
          x = $urandom;
          if (x[30:0] == 31'h0) x = 32'h1;
          cmem[i] = x;
        end
      endcase
    end
  endtask

  task automatic run_job(input int m, input int h, input int w, input bit relu,
                         input int glitch_at, output int cycles);
    wq.delete();
    cur_m = m; cur_h = h; cur_w = w;
    job_empty = (m == 0) || (h / 2 == 0) || (w / 2 == 0);
    c_changes = 0;
    bad_addr = 0;
    @(negedge clk);
    start = 1'b1; relu_en = relu;
    M_val = 5'(m); H_val = 5'(h); W_val = 5'(w);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      start = 1'b0;
      M_val = 5'(m);
      if (cycles == glitch_at) begin
        start = 1'b1;
        M_val = 5'd3;
      end
    end while (!done && cycles < 5000);
    start = 1'b0;
    if (!done) chk("done_timeout", 32'(cycles), 32'hFFFFFFFF);
  endtask

  task automatic check_job(input int m, input int h, input int w, input bit relu, input int cycles);
    int n, i;
    logic [31:0] best, x;
    n = m * (h / 2) * (w / 2);
    chk("cycles_model", 32'(cycles), 32'(6 * n + 2));
    chk("write_count", 32'(wq.size()), 32'(n));
    i = 0;
    for (int mm = 0; mm < m; mm++)
      for (int py = 0; py < h / 2; py++)
        for (int px = 0; px < w / 2; px++) begin
          best = 32'h0;
          for (int t = 0; t < 4; t++) begin
            x = cmem[mm*h*w + (2*py + t/2)*w + 2*px + t%2];
            if (relu && x[31]) x = 32'h0;
            if (t == 0 || fkey(x) > fkey(best)) best = x;
          end
          if (i < wq.size()) begin
            chk("p_addr", 32'(wq[i].a), 32'(i));
            chk("p_wdata", wq[i].d, best);
          end
          i++;
        end
    if (job_empty) chk("c_addr_idle", 32'(c_changes), 32'h0);
    else chk("c_addr_range", 32'(bad_addr), 32'h0);
  endtask

  initial begin
    vec_t tbl [8];
    int cyc;

    tbl[0] = '{1, 2, 2, 1'b0, FILL_A,   0, 1, 8,  32'h40600000, 32'h40600000};
    tbl[1] = '{1, 2, 2, 1'b0, FILL_NEG, 0, 1, 8,  32'hBF000000, 32'hBF000000};
    tbl[2] = '{1, 2, 2, 1'b1, FILL_NEG, 0, 1, 8,  32'h00000000, 32'h00000000};
    tbl[3] = '{2, 4, 4, 1'b0, FILL_IDX, 0, 8, 50, 32'h40A00000, 32'h41F80000};
    tbl[4] = '{1, 3, 5, 1'b0, FILL_IDX, 0, 2, 14, 32'h40C00000, 32'h41000000};
    tbl[5] = '{0, 4, 4, 1'b0, FILL_IDX, 1, 0, 2,  32'h0,        32'h0};
    tbl[6] = '{2, 1, 8, 1'b0, FILL_IDX, 1, 0, 2,  32'h0,        32'h0};
    tbl[7] = '{1, 4, 4, 1'b0, FILL_IDX, 5, 4, 26, 32'h40A00000, 32'h41700000};

    repeat (2) @(negedge clk);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_p_we", 32'(p_we), 32'h0);
    chk("rst_c_addr", 32'(c_addr), 32'h0);
    chk("rst_p_addr", 32'(p_addr), 32'h0);
    chk("rst_p_wdata", p_wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      fill_c(tbl[v].fill, tbl[v].m * tbl[v].h * tbl[v].w);
      run_job(tbl[v].m, tbl[v].h, tbl[v].w, tbl[v].relu, tbl[v].glitch, cyc);
      chk("tbl_cycles", 32'(cyc), 32'(tbl[v].exp_cyc));
      chk("tbl_nwrites", 32'(wq.size()), 32'(tbl[v].exp_n));
      if (wq.size() > 0) begin
        chk("tbl_first", wq[0].d, tbl[v].exp_first);
        chk("tbl_last", wq[wq.size()-1].d, tbl[v].exp_last);
      end
      check_job(tbl[v].m, tbl[v].h, tbl[v].w, tbl[v].relu, cyc);
    end

    for (int r = 0; r < 8; r++) begin
      int m, h, w;
      bit relu;
      m = $urandom_range(1, 3);
      h = $urandom_range(2, 9);
      w = $urandom_range(2, 9);
      relu = 1'($urandom_range(0, 1));
      fill_c(FILL_RND, m * h * w);
      run_job(m, h, w, relu, 0, cyc);
      check_job(m, h, w, relu, cyc);
    end

    // abort during the third output's WRITE cycle, then rerun the same job
    fill_c(FILL_IDX, 16);
    wq.delete();
    @(negedge clk);
    start = 1'b1; relu_en = 1'b0; M_val = 5'd1; H_val = 5'd4; W_val = 5'd4;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (wq.size() < 3 && cyc < 500) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("abort_reached", 32'(wq.size()), 32'h3);
    rst_n = 1'b0;
    #1;
    chk("abort_p_we", 32'(p_we), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'h0);
    run_job(1, 4, 4, 1'b0, 0, cyc);
    check_job(1, 4, 4, 1'b0, cyc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
